// File: rtl/uart_word_fetch.sv
// UART fetch engine: sends a request address as 8N1 bytes on tx, then assembles a DATA_W-bit reply from rx.
// Define UART_WORD_FETCH_PARITY_EN for 8E1 framing with even-parity generation and checking.
module uart_word_fetch #(
  parameter int BIT_DIV     = 163,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              rx,
  output logic              tx,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [2:0]        state_dbg
);
  // Handshake: a request transfers on a clk edge with req_valid && req_ready; req_ready is high only
  // in IDLE. rsp_valid is a single-cycle pulse with no back-pressure; rsp_err qualifies it.

  localparam int NB_TX = ADDR_W / 8;
  localparam int NB_RX = DATA_W / 8;
  localparam int HALF  = BIT_DIV / 2;
  localparam int BCW   = $clog2(BIT_DIV);
  localparam int TOW   = $clog2(TIMEOUT_CYC + 1);
`ifdef UART_WORD_FETCH_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_START = 3'd1,
    TX_BITS  = 3'd2,
    TX_STOP  = 3'd3,
    RX_WAIT  = 3'd4,
    RX_BITS  = 3'd5,
    RX_STOP  = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [BCW-1:0]    bit_cnt;
  logic [3:0]        bit_idx;
  logic [3:0]        byte_idx;
  logic [TOW-1:0]    to_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;
  logic              rx_s1, rx_s2, rx_prev;
  logic              start_chk;
  logic              tx_nx;
  logic              par;

  logic bit_end, half_end, last_tx, last_rx, to_hit, fall, frame_bad;
  assign bit_end   = (bit_cnt == BCW'(BIT_DIV - 1));
  assign half_end  = (bit_cnt == BCW'(HALF - 1));
  assign last_tx   = (byte_idx == 4'(NB_TX - 1));
  assign last_rx   = (byte_idx == 4'(NB_RX - 1));
  assign to_hit    = (to_cnt == TOW'(TIMEOUT_CYC - 1));
  assign fall      = rx_prev & ~rx_s2;
  assign frame_bad = ~rx_s2 | par;

`ifdef UART_WORD_FETCH_PARITY_EN
  // Running XOR over the data bits; on RX it also absorbs the parity bit, so nonzero means mismatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par <= 1'b0;
    else if (state == TX_START || state == RX_WAIT) par <= 1'b0;
    else if (state == TX_BITS && bit_end && bit_idx < 4'd8) par <= par ^ addr_sh[0];
    else if (state == RX_BITS && !start_chk && bit_end) par <= par ^ rx_s2;
  end
`else
  assign par = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (req_valid) state_nx = TX_START;
      TX_START: if (bit_end) state_nx = TX_BITS;
      TX_BITS:  if (bit_end && bit_idx == 4'(NBITS - 1)) state_nx = TX_STOP;
      TX_STOP:  if (bit_end) state_nx = last_tx ? RX_WAIT : TX_START;
      RX_WAIT: begin
        if (to_hit)    state_nx = DONE;
        else if (fall) state_nx = RX_BITS;
      end
      RX_BITS: begin
        if (start_chk) begin
          if (half_end && rx_s2) state_nx = RX_WAIT;
        end else if (bit_end && bit_idx == 4'(NBITS - 1)) begin
          state_nx = RX_STOP;
        end
      end
      RX_STOP:  if (bit_end) state_nx = (frame_bad || last_rx) ? DONE : RX_WAIT;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx_nx = 1'b1;
    case (state)
      TX_START: tx_nx = 1'b0;
      TX_BITS:  tx_nx = bit_idx[3] ? par : addr_sh[0];
      default:  tx_nx = 1'b1;
    endcase
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == DONE);
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx        <= 1'b1;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      to_cnt    <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      start_chk <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      tx      <= tx_nx;
      // Zero everywhere outside RX_WAIT, so every entry (including a glitch return) starts fresh.
      to_cnt  <= (state == RX_WAIT) ? to_cnt + TOW'(1) : '0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (req_valid) addr_sh <= req_addr;
        end
        TX_START: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + BCW'(1);
          bit_idx <= '0;
        end
        TX_BITS: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + BCW'(1);
          if (bit_end) begin
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx < 4'd8) addr_sh <= addr_sh >> 1;
          end
        end
        TX_STOP: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + BCW'(1);
          if (bit_end) byte_idx <= last_tx ? '0 : byte_idx + 4'd1;
        end
        RX_WAIT: begin
          bit_cnt   <= '0;
          bit_idx   <= '0;
          start_chk <= 1'b1;
          if (to_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RX_BITS: begin
          if (start_chk) begin
            bit_cnt <= half_end ? '0 : bit_cnt + BCW'(1);
            if (half_end) start_chk <= 1'b0;
          end else begin
            bit_cnt <= bit_end ? '0 : bit_cnt + BCW'(1);
            if (bit_end) begin
              bit_idx <= bit_idx + 4'd1;
              if (bit_idx < 4'd8) data_sh <= {rx_s2, data_sh[DATA_W-1:1]};
            end
          end
        end
        RX_STOP: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + BCW'(1);
          if (bit_end) begin
            byte_idx <= byte_idx + 4'd1;
            if (frame_bad || last_rx) begin
              rsp_data <= frame_bad ? '0 : data_sh;
              rsp_err  <= frame_bad;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_fetch.sv
// Bench for uart_word_fetch: decodes tx against expected address bytes, plays a remote UART on rx,
// and scores responses from an expected queue.
module tb_uart_word_fetch;
  localparam int BD = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 500;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rx = 1'b1;
  logic          tx;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic [2:0]    state_dbg;

  logic [W-1:0] exp_q[$];
  logic [7:0]   tx_q[$];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;
  int rsp_count = 0;
  logic prev_rsp = 1'b0;

  uart_word_fetch #(
    .BIT_DIV(BD), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rx(rx), .tx(tx), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // response scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_rsp = 1'b0;
    end else begin
      if (prev_rsp) begin
        check("rsp_pulse_width", rsp_valid, 0);
        check("req_ready_after_done", req_ready, 1);
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        rsp_count++;
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp", {rsp_err, rsp_data}, exp_q.pop_front());
      end
      prev_rsp = rsp_valid;
    end
  end

  // drivers
  task automatic do_req(input logic [AW-1:0] a);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    for (int k = 0; k < AW / 8; k++) tx_q.push_back(a[8*k +: 8]);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    check("busy_after_accept", busy, 1);
  endtask

  // Samples each tx bit mid-cell; tx is registered, so the start bit begins one clock after acceptance.
  task automatic tx_check(input int nbytes);
    logic [7:0] b;
    @(negedge clk);
    check("tx_high_at_accept", tx, 1);
    @(negedge clk);
    check("tx_first_start", tx, 0);
    repeat (BD / 2 - 1) @(negedge clk);
    for (int k = 0; k < nbytes; k++) begin
      if (k > 0) repeat (BD) @(negedge clk);
      check("tx_start", tx, 0);
      for (int j = 0; j < 8; j++) begin
        repeat (BD) @(negedge clk);
        b[j] = tx;
      end
      repeat (BD) @(negedge clk);
      check("tx_stop", tx, 1);
      if (tx_q.size() == 0) check("tx_byte_unexpected", 1, 0);
      else check("tx_byte", b, tx_q.pop_front());
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx = b[j];
      repeat (BD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
  endtask

  // bad_byte < 0 sends a clean word; otherwise that byte gets a 0 stop bit and sending stops there.
  task automatic send_word(input logic [DW-1:0] w, input int bad_byte);
    for (int k = 0; k < DW / 8; k++) begin
      send_byte(w[8*k +: 8], (k == bad_byte) ? 1'b0 : 1'b1);
      if (k == bad_byte) break;
    end
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (rsp_count >= n) break;
    end
    check("rsp_arrived", rsp_count, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // normal fetch
    do_req(32'h12345678);
    tx_check(4);
    repeat (BD) @(negedge clk);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    fork send_word(32'hDEADBEEF, -1); join_none
    wait_rsp(1, 1000);

    // silent remote: RX_WAIT is entered 10*BD*(AW/8) clocks after acceptance
    do_req(32'hA5A50F0F);
    tx_check(4);
    exp_q.push_back({1'b1, 32'h0});
    wait_rsp(2, 1000);
    check("timeout_latency", rsp_cyc - acc_cyc, 10 * BD * (AW / 8) + TO);

    // framing error on byte 1, then a back-to-back request
    do_req(32'h000000F1);
    tx_check(4);
    repeat (BD) @(negedge clk);
    exp_q.push_back({1'b1, 32'h0});
    fork send_word(32'hDEADBEEF, 1); join_none
    wait_rsp(3, 1000);
    do_req(32'h0BADF00D);
    tx_check(4);
    repeat (BD) @(negedge clk);
    exp_q.push_back({1'b0, 32'h44332211});
    fork send_word(32'h44332211, -1); join_none
    wait_rsp(4, 1000);

    // 3-clock glitch on rx, then a real word
    do_req(32'h00C0FFEE);
    tx_check(4);
    repeat (BD) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
    exp_q.push_back({1'b0, 32'h8001AA55});
    fork send_word(32'h8001AA55, -1); join_none
    wait_rsp(5, 1000);

    // reset halfway through the second address byte (byte is 0x00, so tx would otherwise be 0)
    do_req(32'hCAFE0081);
    tx_check(1);
    tx_q.delete();
    repeat (88) @(negedge clk);
    check("busy_mid_tx", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_rsp_data", rsp_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_rsp_after_reset", rsp_count, 5);
    do_req(32'h87654321);
    tx_check(4);
    repeat (BD) @(negedge clk);
    exp_q.push_back({1'b0, 32'hDF9B5713});
    fork send_word(32'hDF9B5713, -1); join_none
    wait_rsp(6, 1000);

    repeat (2 * BD) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
